// File: rtl/io_write_scheduler.sv
// io_write_scheduler: shares the output-port write bus between a buffered CPU
// store path and an unbuffered auxiliary master. CPU writes are queued in a
// small FIFO and arbitrated round-robin against the auxiliary master. An
// optional idle gap follows each issued write.
//
// state  | meaning
// IDLE   | bus free, arbitrate on every edge
// ISSUE  | write strobe high this cycle
// WAIT   | forced idle gap after a write, gap_q counts down
module io_write_scheduler #(
    parameter int DEPTH = 4,
    parameter int GAP   = 0
) (
    input  logic                    io_clk_i,
    input  logic                    reset_i,
    input  logic                    cpu_req_i,
    input  logic [31:0]             cpu_addr_i,
    input  logic [31:0]             cpu_data_i,
    output logic                    cpu_ready_o,
    input  logic                    aux_req_i,
    input  logic [31:0]             aux_addr_i,
    input  logic [31:0]             aux_data_i,
    output logic                    aux_ack_o,
    output logic [31:0]             io_addr_o,
    output logic [31:0]             io_data_o,
    output logic                    write_io_enable_o,
    output logic                    busy_o,
    output logic [$clog2(DEPTH):0]  fifo_count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [2:0]    GAP_LOAD   = (GAP > 0) ? 3'(GAP - 1) : 3'd0;

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;
    typedef enum logic {GNT_CPU, GNT_AUX} grant_t;

    state_t          state_q, state_d;
    grant_t          last_q, last_d;
    logic [2:0]      gap_q, gap_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [31:0]     io_addr_q, io_addr_d, io_data_q, io_data_d;
    logic            wen_q, wen_d, ack_q, ack_d;
    logic [31:0]     mem_addr_q [DEPTH];
    logic [31:0]     mem_data_q [DEPTH];

    logic            push, pop, decide, cpu_elig, aux_elig, grant_cpu, grant_aux;

    assign cpu_ready_o       = (count_q < FULL_COUNT);
    assign aux_ack_o         = ack_q;
    assign io_addr_o         = io_addr_q;
    assign io_data_o         = io_data_q;
    assign write_io_enable_o = wen_q;
    assign fifo_count_o      = count_q;
    assign busy_o            = (count_q != '0) || (state_q != ST_IDLE);

    // Eligibility and round-robin arbitration. The last WAIT cycle doubles as a
    // decision edge so that back-to-back writes are exactly 1+GAP cycles apart.
    always_comb begin
        push      = cpu_req_i && cpu_ready_o;
        cpu_elig  = (count_q != '0);
        aux_elig  = aux_req_i && !ack_q;
        decide    = (state_q == ST_IDLE) ||
                    ((state_q == ST_ISSUE) && (GAP == 0)) ||
                    ((state_q == ST_WAIT) && (gap_q == 3'd0));
        grant_cpu = 1'b0;
        grant_aux = 1'b0;
        if (decide) begin
            if (cpu_elig && aux_elig) begin
                grant_cpu = (last_q == GNT_AUX);
                grant_aux = (last_q == GNT_CPU);
            end else begin
                grant_cpu = cpu_elig;
                grant_aux = aux_elig;
            end
        end
        pop = grant_cpu;
    end

    // FIFO pointer and occupancy update; a refused push never moves wr_ptr.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Next state, bus outputs and gap counter.
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        gap_d     = gap_q;
        io_addr_d = io_addr_q;
        io_data_d = io_data_q;
        wen_d     = 1'b0;
        ack_d     = 1'b0;
        if (grant_cpu || grant_aux) begin
            state_d = ST_ISSUE;
            wen_d   = 1'b1;
            ack_d   = grant_aux;
            if (grant_aux) begin
                io_addr_d = aux_addr_i;
                io_data_d = aux_data_i;
                last_d    = GNT_AUX;
            end else begin
                io_addr_d = mem_addr_q[rd_ptr_q];
                io_data_d = mem_data_q[rd_ptr_q];
                last_d    = GNT_CPU;
            end
        end else begin
            case (state_q)
                ST_ISSUE: begin
                    if (GAP == 0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_WAIT;
                        gap_d   = GAP_LOAD;
                    end
                end
                ST_WAIT: begin
                    if (gap_q == 3'd0) state_d = ST_IDLE;
                    else               gap_d   = gap_q - 1'b1;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State registers; reset discards queued entries by clearing pointers.
    always_ff @(posedge io_clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= ST_IDLE;
            last_q    <= GNT_AUX;
            gap_q     <= 3'd0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            io_addr_q <= 32'd0;
            io_data_q <= 32'd0;
            wen_q     <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            gap_q     <= gap_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            io_addr_q <= io_addr_d;
            io_data_q <= io_data_d;
            wen_q     <= wen_d;
            ack_q     <= ack_d;
        end
    end

    // FIFO storage, written on accepted pushes only.
    always_ff @(posedge io_clk_i) begin
        if (push) begin
            mem_addr_q[wr_ptr_q] <= cpu_addr_i;
            mem_data_q[wr_ptr_q] <= cpu_data_i;
        end
    end

endmodule
